// File: rtl/hazard_unit_pkg.sv
// Shared pipeline constants: multiplier sequencer states, opcode/funct7 and ALUOp encodings.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mult_state_e;

  localparam logic [6:0] FUNCT7_MULT = 7'b0000001;

  localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
  localparam logic [6:0] OPC_ITYPE  = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  localparam logic [1:0] ALUOP_ADD    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
  localparam logic [1:0] ALUOP_IMM    = 2'b11;

endpackage

// File: rtl/hazard_unit_mult_seq.sv
// Multiplier sequencer: holds a multiply in EX for MULT_LATENCY cycles, then pulses mult_done.
module mult_seq
  import hazard_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 4
) (
  input  logic clk,
  input  logic arst_n,
  input  logic ex_mult,
  output logic mult_stall,
  output logic mult_done
);

  localparam int CNT_W = $clog2(MULT_LATENCY);
  // IDLE and DONE each take one EX cycle, so BUSY covers the remaining MULT_LATENCY-2.
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY - 3);

  mult_state_e      state_reg;
  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (ex_mult) begin
            state_reg <= ST_BUSY;
            cnt_reg   <= CNT_LOAD;
          end
        end
        ST_BUSY: begin
          if (cnt_reg == '0) state_reg <= ST_DONE;
          else               cnt_reg   <= cnt_reg - CNT_W'(1);
        end
        ST_DONE: state_reg <= ST_IDLE;
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign mult_stall = ((state_reg == ST_IDLE) && ex_mult) || (state_reg == ST_BUSY);
  assign mult_done  = (state_reg == ST_DONE);

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard control: multiply stall > load-use stall > flush.
// Optional stall-cycle counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MULT_LATENCY = 4
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_flush,
  input  logic        ex_mem_read,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mult,
  output logic        pc_write,
  output logic        if_id_write,
  output logic        if_id_flush,
  output logic        id_ex_bubble,
  output logic        ex_stall,
  output logic        ex_mem_bubble,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] stall_cycles,
`endif
  output logic        mult_done
);

  logic mult_stall;
  logic load_use;

  mult_seq #(
    .MULT_LATENCY(MULT_LATENCY)
  ) u_mult_seq (
    .clk       (clk),
    .arst_n    (arst_n),
    .ex_mult   (ex_mult),
    .mult_stall(mult_stall),
    .mult_done (mult_done)
  );

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_bubble  = 1'b0;
    ex_stall      = 1'b0;
    ex_mem_bubble = 1'b0;
    if (mult_stall) begin
      pc_write      = 1'b0;
      if_id_write   = 1'b0;
      ex_stall      = 1'b1;
      ex_mem_bubble = 1'b1;
    end else if (load_use) begin
      // A flush dropped here is re-raised once the held branch re-issues.
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush = id_flush;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cnt_reg;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n)        stall_cnt_reg <= '0;
    else if (!pc_write) stall_cnt_reg <= stall_cnt_reg + 32'd1;
  end

  assign stall_cycles = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: vector table, directed multi-cycle sequences, random vs. model.
module tb_hazard_unit;

  localparam int ML = 4;

  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_stall;
    logic ex_mem_bubble;
    logic mult_done;
  } outs_t;

  typedef struct {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       mem_read;
    logic       flush;
    outs_t      exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        arst_n = 1'b0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_flush = 1'b0;
  logic        ex_mem_read = 1'b0;
  logic [4:0]  ex_rd = '0;
  logic        ex_mult = 1'b0;
  logic        pc_write, if_id_write, if_id_flush, id_ex_bubble;
  logic        ex_stall, ex_mem_bubble, mult_done;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int m_cnt    = 0;   // cycles the current multiply has already spent in EX
  int perf_model = 0;

  always #5 clk = ~clk;

  hazard_unit #(.MULT_LATENCY(ML)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_flush     (id_flush),
    .ex_mem_read  (ex_mem_read),
    .ex_rd        (ex_rd),
    .ex_mult      (ex_mult),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_bubble (id_ex_bubble),
    .ex_stall     (ex_stall),
    .ex_mem_bubble(ex_mem_bubble),
`ifdef HAZARD_PERF_CNT_EN
    .stall_cycles (stall_cycles),
`endif
    .mult_done    (mult_done)
  );

  function automatic outs_t dut_outs();
    outs_t o;
    o = '{pc_write, if_id_write, if_id_flush, id_ex_bubble, ex_stall, ex_mem_bubble, mult_done};
    return o;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // One cycle against the reference model; called at posedge+1, returns at next posedge+1.
  task automatic run_cycle(input string name);
    outs_t exp;
    bit stall, done, lu;
    int nxt;
    if (m_cnt == 0) begin
      stall = ex_mult;
      done  = 1'b0;
    end else begin
      done  = (m_cnt + 1 == ML);
      stall = !done;
    end
    lu = ex_mem_read && ex_rd != 0 && (ex_rd == id_rs1 || ex_rd == id_rs2);
    if (stall)   exp = 7'b0000110;
    else if (lu) exp = {6'b000100, done};
    else         exp = {2'b11, id_flush, 3'b000, done};
    nxt = done ? 0 : (stall ? m_cnt + 1 : 0);
    #4;
    check(name, 32'(dut_outs()), 32'(exp));
    if (!exp.pc_write) perf_model++;
    @(posedge clk);
    m_cnt = nxt;
    #1;
  endtask

  task automatic set_in(input logic mult, input logic mr, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic fl);
    ex_mult = mult; ex_mem_read = mr; ex_rd = rd;
    id_rs1 = rs1; id_rs2 = rs2; id_flush = fl;
  endtask

  task automatic do_reset();
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    arst_n = 1'b0;
    #2;
    check("reset_outs", 32'(dut_outs()), 32'(7'b1100000));
`ifdef HAZARD_PERF_CNT_EN
    check("reset_stall_cycles", stall_cycles, 32'd0);
`endif
    m_cnt = 0;
    perf_model = 0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
  endtask

  vec_t vecs[8];

  initial begin
    int dones;
    vecs[0] = '{5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 7'b1100000};
    vecs[1] = '{5'd9,  5'd5,  5'd5,  1'b1, 1'b0, 7'b0001000};
    vecs[2] = '{5'd0,  5'd4,  5'd0,  1'b1, 1'b0, 7'b1100000};
    vecs[3] = '{5'd5,  5'd6,  5'd5,  1'b0, 1'b0, 7'b1100000};
    vecs[4] = '{5'd7,  5'd1,  5'd7,  1'b1, 1'b1, 7'b0001000};
    vecs[5] = '{5'd7,  5'd1,  5'd8,  1'b1, 1'b1, 7'b1110000};
    vecs[6] = '{5'd31, 5'd31, 5'd31, 1'b1, 1'b0, 7'b0001000};
    vecs[7] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 7'b1110000};

    do_reset();

    foreach (vecs[i]) begin
      set_in(1'b0, vecs[i].mem_read, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].flush);
      #4;
      check($sformatf("vec%0d", i), 32'(dut_outs()), 32'(vecs[i].exp));
      @(posedge clk);
      #1;
    end

    // Back-to-back multiplies: stall 3 cycles, done on 4 and 8, restart on 5.
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    dones = 0;
    for (int c = 1; c <= 8; c++) begin
      #4;
      check($sformatf("mult_c%0d_ex_stall", c), 32'(ex_stall), 32'((c % 4) != 0));
      check($sformatf("mult_c%0d_done", c), 32'(mult_done), 32'((c % 4) == 0));
      if (mult_done) dones++;
      @(posedge clk);
      #1;
    end
    check("mult_done_pulses", 32'(dones), 32'd2);
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    run_cycle("after_mult_idle");

    // Illegal mult+load: treated as multiply stall.
    set_in(1'b1, 1'b1, 5'd5, 5'd5, 5'd0, 1'b1);
    run_cycle("mult_and_load");
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle("mult_and_load_drain");

    // Asynchronous reset in the middle of BUSY abandons the multiply.
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    run_cycle("rst_mid_c1");
    ex_mult = 1'b0;
    run_cycle("rst_mid_c2");
    #1;
    check("rst_mid_busy_stall", 32'(ex_stall), 32'd1);
    arst_n = 1'b0;
    #1;
    check("rst_async_ex_stall", 32'(ex_stall), 32'd0);
    check("rst_async_outs", 32'(dut_outs()), 32'(7'b1100000));
    m_cnt = 0;
    perf_model = 0;
    @(posedge clk);
    #1;
    arst_n = 1'b1;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      #4;
      if (mult_done) dones++;
      @(posedge clk);
      #1;
    end
    check("rst_no_mult_done", 32'(dones), 32'd0);

`ifdef HAZARD_PERF_CNT_EN
    do_reset();
    set_in(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    run_cycle("perf_mult");
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    for (int c = 0; c < 3; c++) run_cycle("perf_mult_rest");
    set_in(1'b0, 1'b1, 5'd3, 5'd3, 5'd1, 1'b0);
    run_cycle("perf_load_use");
    set_in(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    #1;
    check("perf_stall_cycles", stall_cycles, 32'd4);
    @(posedge clk);
    #1;
`endif

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      set_in(($urandom_range(0, 5) == 0), ($urandom_range(0, 2) == 0),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      run_cycle($sformatf("rand%0d", c));
    end
`ifdef HAZARD_PERF_CNT_EN
    check("rand_stall_cycles", stall_cycles, 32'(perf_model));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
